// File: rtl/ysyx_lsu_axi_if.sv
// AXI4-Lite master bus used by the LSU adapter: AR/R/AW/W/B channels bundled
// into one interface, with master (adapter) and slave (memory) views.
interface ysyx_lsu_axi_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready,
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready
    );

    modport slave (
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready,
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready
    );
endinterface

// File: rtl/ysyx_lsu_axi.sv
// LSU-to-AXI4-Lite adapter: one transaction at a time, lane alignment of data and
// strobes, misaligned rejection, and a registered single-cycle completion pulse.
module ysyx_lsu_axi #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic              lsu_arvalid,
    input  logic [7:0]        lsu_rstrb,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_rvalid,
    input  logic [ADDR_W-1:0] lsu_awaddr,
    input  logic              lsu_awvalid,
    input  logic              lsu_wvalid,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wstrb,
    output logic              lsu_wready,
    output logic              lsu_err,
    ysyx_lsu_axi_if.master    axi
);

    typedef enum logic [2:0] {IDLE, AR, R, WR, B, RESP, DRAIN} state_e;

    state_e            state_q, state_d;
    logic [1:0]        off_q, off_d;
    logic [3:0]        strb_q, strb_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              lsu_rvalid_q, lsu_rvalid_d;
    logic              lsu_wready_q, lsu_wready_d;
    logic              lsu_err_q, lsu_err_d;
    logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;

    logic              req_store;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_strb;
    logic [6:0]        req_lane;
    logic              req_mis;
    logic [4:0]        req_sh;
    logic [4:0]        rsh;
    logic [DATA_W-1:0] rmask;
    logic              aw_fire;
    logic              w_fire;

    logic unused_inputs;
    assign unused_inputs = ^{lsu_rstrb[7:4], lsu_wstrb[7:4], lsu_wvalid};

    always_comb begin
        req_store = lsu_awvalid;
        req_addr  = lsu_awvalid ? lsu_awaddr : lsu_araddr;
        req_strb  = lsu_awvalid ? lsu_wstrb[3:0] : lsu_rstrb[3:0];
        req_sh    = {req_addr[1:0], 3'b000};
        // A strobe shifted past lane 3 means the access crosses the word boundary.
        req_lane  = {3'b000, req_strb} << req_addr[1:0];
        req_mis   = |req_lane[6:4];
        rsh       = {off_q, 3'b000};
        rmask     = '0;
        for (int i = 0; i < 4; i++) begin
            rmask[8*i +: 8] = {8{strb_q[i]}};
        end
        aw_fire   = awvalid_q && axi.awready;
        w_fire    = wvalid_q && axi.wready;

        state_d      = state_q;
        off_d        = off_q;
        strb_d       = strb_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        araddr_d     = araddr_q;
        awaddr_d     = awaddr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        lsu_rvalid_d = lsu_rvalid_q;
        lsu_wready_d = lsu_wready_q;
        lsu_err_d    = lsu_err_q;
        lsu_rdata_d  = lsu_rdata_q;

        case (state_q)
            IDLE: begin
                if (lsu_awvalid || lsu_arvalid) begin
                    off_d  = req_addr[1:0];
                    strb_d = req_strb;
                    if (req_mis) begin
                        state_d   = RESP;
                        lsu_err_d = 1'b1;
                        if (req_store) begin
                            lsu_wready_d = 1'b1;
                        end else begin
                            lsu_rvalid_d = 1'b1;
                            lsu_rdata_d  = '0;
                        end
                    end else if (req_store) begin
                        state_d   = WR;
                        awaddr_d  = req_addr;
                        wdata_d   = lsu_wdata << req_sh;
                        wstrb_d   = req_lane[3:0];
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = AR;
                        araddr_d  = req_addr;
                        arvalid_d = 1'b1;
                    end
                end
            end
            AR: begin
                if (axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = R;
                end
            end
            R: begin
                if (axi.rvalid) begin
                    rready_d     = 1'b0;
                    lsu_rdata_d  = (axi.rdata >> rsh) & rmask;
                    lsu_err_d    = (axi.rresp != 2'b00);
                    lsu_rvalid_d = 1'b1;
                    state_d      = RESP;
                end
            end
            WR: begin
                aw_done_d = aw_done_q | aw_fire;
                w_done_d  = w_done_q | w_fire;
                if (aw_fire) awvalid_d = 1'b0;
                if (w_fire)  wvalid_d  = 1'b0;
                if (aw_done_d && w_done_d) begin
                    bready_d = 1'b1;
                    state_d  = B;
                end
            end
            B: begin
                if (axi.bvalid) begin
                    bready_d     = 1'b0;
                    lsu_err_d    = (axi.bresp != 2'b00);
                    lsu_wready_d = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                lsu_rvalid_d = 1'b0;
                lsu_wready_d = 1'b0;
                lsu_err_d    = 1'b0;
                state_d      = DRAIN;
            end
            DRAIN: begin
                // Requests are level-held; wait for the LSU to drop them before re-arming.
                if (!lsu_arvalid && !lsu_awvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            off_q        <= '0;
            strb_q       <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            araddr_q     <= '0;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            lsu_wready_q <= 1'b0;
            lsu_err_q    <= 1'b0;
            lsu_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            off_q        <= off_d;
            strb_q       <= strb_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            araddr_q     <= araddr_d;
            awaddr_q     <= awaddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            lsu_rvalid_q <= lsu_rvalid_d;
            lsu_wready_q <= lsu_wready_d;
            lsu_err_q    <= lsu_err_d;
            lsu_rdata_q  <= lsu_rdata_d;
        end
    end

    assign axi.araddr  = araddr_q;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;
    assign axi.awaddr  = awaddr_q;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;
    assign lsu_rvalid  = lsu_rvalid_q;
    assign lsu_wready  = lsu_wready_q;
    assign lsu_err     = lsu_err_q;
    assign lsu_rdata   = lsu_rdata_q;

endmodule

// File: doc/ysyx_lsu_axi.md
# ysyx_lsu_axi

Bus-side master adapter directly downstream of the load/store unit. Accepts the LSU's level-valid load and store requests (address, byte strobe, data), aligns data and strobes to the 32-bit bus word, and runs one AXI4-Lite transaction at a time. Returns a registered single-cycle completion pulse (`lsu_rvalid` / `lsu_wready`) with right-aligned load data. Misaligned accesses that cross a word boundary are rejected without touching the bus.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; bus word is 4 bytes

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `lsu_araddr`  in  ADDR_W  load address
- `lsu_arvalid`  in  1  load request, level, held until completion
- `lsu_rstrb`  in  8  load size: 8'h1 byte, 8'h3 half, 8'hf word
- `lsu_rdata`  out  DATA_W  load data, shifted right by 8*addr[1:0]
- `lsu_rvalid`  out  1  load-complete pulse
- `lsu_awaddr`  in  ADDR_W  store address
- `lsu_awvalid`, `lsu_wvalid`  in  1  store request (both asserted together)
- `lsu_wdata`  in  DATA_W  store data, right-aligned
- `lsu_wstrb`  in  8  store size, same encoding as `lsu_rstrb`
- `lsu_wready`  out  1  store-complete pulse
- `lsu_err`  out  1  error, valid with completion pulse (misaligned or resp≠0)
- AXI AR: `araddr` out ADDR_W, `arvalid` out 1, `arready` in 1
- AXI R: `rdata` in DATA_W, `rresp` in 2, `rvalid` in 1, `rready` out 1
- AXI AW: `awaddr` out ADDR_W, `awvalid` out 1, `awready` in 1
- AXI W: `wdata` out DATA_W, `wstrb` out 4, `wvalid` out 1, `wready` in 1
- AXI B: `bresp` in 2, `bvalid` in 1, `bready` out 1

## Operation
- States: IDLE, AR, R, WR, B, RESP, DRAIN.
- IDLE: store (`lsu_awvalid`) has priority over load. Latch address, size, data; go to WR or AR. A pending load stays pending, since its valid is still high.
- Misalign check at accept:
  - half with addr[1:0]==3, or word with addr[1:0]≠0, is misaligned.
  - Skip the bus and go straight to RESP with `lsu_err`=1 and `lsu_rdata`=0.
- AR: `arvalid`=1 with `araddr`=latched full address. On `arready`, go to R.
- R: `rready`=1. On `rvalid`:
  - capture `rdata` >> 8*addr[1:0], masked to the size (no sign extension; the LSU extends);
  - `lsu_err`=(`rresp`≠0);
  - go to RESP.
- WR: `awvalid` and `wvalid` are asserted together.
  - `wdata` = latched data << 8*addr[1:0].
  - `wstrb` = size strobe[3:0] << addr[1:0].
  - Each valid drops after its own handshake, tracked by `aw_done` / `w_done` flags. Same-cycle handshakes are allowed.
  - When both are done, go to B.
- B: `bready`=1. On `bvalid`: `lsu_err`=(`bresp`≠0), go to RESP.
- RESP: exactly one cycle with `lsu_rvalid`=1 (load) or `lsu_wready`=1 (store); `lsu_err` is valid in the same cycle. Go to DRAIN.
- DRAIN: wait until `lsu_arvalid`=0 and `lsu_awvalid`=0, then go to IDLE. This prevents re-issuing a still-asserted request.
- `lsu_rdata` holds its value until the next load completes.

## Timing
- Reset (async assert):
  - state=IDLE;
  - all AXI valid/ready outputs, `lsu_rvalid`, `lsu_wready`, `lsu_err` = 0;
  - `lsu_rdata`, `araddr`, `awaddr`, `wdata`, `wstrb` = 0.
- Reset mid-transaction aborts immediately with outputs forced to 0. No completion pulse is ever produced for the aborted request.
- All outputs are registered or decoded from state only. There are no combinational paths from AXI inputs to LSU outputs.
- Load latency: accept at edge E0; with zero-wait slave (`arready` high at E1, `rvalid` high at E2), `lsu_rvalid` is high in cycle E2–E3. The minimum is 3 cycles from accept to pulse.
- Store latency: accept E0; AW and W handshake at E1; `bvalid` at E2; `lsu_wready` is high in E2–E3.
- Misaligned access: accept E0, pulse in E0–E1.
- Wait states: AR/AW/W valids stay stable with constant payload until their ready. Valid never depends on ready.
- Back-to-back: the next request is accepted no earlier than one cycle after RESP (DRAIN lasts at least 1 cycle).

## Test plan
- Word load at 0x8000_0004, `rdata`=0xDEAD_BEEF, zero-wait slave:
  - `araddr`=0x8000_0004;
  - `lsu_rvalid` pulses once, 3 cycles after accept;
  - `lsu_rdata`=0xDEAD_BEEF, `lsu_err`=0.
- Byte load at 0x8000_0003, `rdata`=0xAB12_3456, `arready` delayed 4 cycles:
  - `arvalid` held 5 cycles;
  - `lsu_rdata`=0x0000_00AB.
- Half store at 0x8000_0002, data 0x0000_1234:
  - `wdata`=0x1234_0000, `wstrb`=4'b1100;
  - `wready` arrives 2 cycles before `awready`: `wvalid` drops first, B entered only after AW;
  - one `lsu_wready` pulse.
- Word store at 0x8000_0001: no AXI valid ever asserted; `lsu_wready`=1 and `lsu_err`=1 in the cycle after accept.
- Load with `rresp`=2'b10: `lsu_rvalid`=1 with `lsu_err`=1. Holding `lsu_arvalid` high 5 cycles after the pulse issues no second AR.
- Assert `rst_n`=0 while in R (`rready`=1): `rready`, `lsu_rvalid` = 0 immediately; after release, a new store completes normally.
